fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the datapath decoder.
- Holds the fetch PC and issues in-order word requests to instruction memory. Buffers returned words in a small FIFO and presents {instruction, PC} to decode over a valid/ready handshake.
- Accepts PC redirects from decode (early JAL) and from execute (branch/JALR resolve). On a redirect it flushes buffered words and silently discards responses still in flight.

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting in front of the decoder.
//
// Keeps the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words together with their PCs in a small FIFO and hands
// {instruction, PC} to decode over a valid/ready handshake. Redirects from
// decode or execute flush the buffer. Responses that are still in flight
// when a redirect happens are counted as "drop" and discarded on arrival.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req_valid/ready/addr         word request to instruction memory
//   imem_resp_valid/data              in-order response words
//   redirect_valid/pc                 PC redirect (highest priority)
//   if_valid/ready, if_instr, if_pc   instruction handed to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [3:0]  MAX_C   = 4'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_r, state_s;

  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic [31:0] resp_pc_r, resp_pc_s;   // PC of the next live response
  logic        req_valid_r, req_valid_s;
  logic [3:0]  live_r, live_s;         // requests whose words will be kept
  logic [3:0]  drop_r, drop_s;         // requests whose words will be discarded
  logic [3:0]  count_r, count_s;       // FIFO occupancy
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0] instr_mem_r [FIFO_DEPTH];
  logic [31:0] pc_mem_r    [FIFO_DEPTH];

  logic        accept_s;
  logic        dropped_s;
  logic        pushed_s;
  logic        write_s;
  logic        pop_s;
  logic [31:0] target_s;

  // Handshake and response classification for the current cycle.
  always_comb begin
    accept_s  = req_valid_r & imem_req_ready;
    dropped_s = imem_resp_valid & (drop_r != 4'd0);
    pushed_s  = imem_resp_valid & (drop_r == 4'd0) & (live_r != 4'd0);
    // A live word arriving together with a redirect belongs to the old stream.
    write_s   = pushed_s & ~redirect_valid;
    pop_s     = (count_r != 4'd0) & if_ready;
    target_s  = redirect_pc & 32'hFFFF_FFFC;
  end

  // FSM next state: a single BOOT cycle, then RUN forever.
  always_comb begin
    state_s = state_r;
    case (state_r)
      BOOT:    state_s = RUN;
      RUN:     state_s = RUN;
      default: state_s = BOOT;
    endcase
  end

  // Next values of counters, PCs and the registered request valid.
  always_comb begin
    live_s    = live_r;
    drop_s    = drop_r;
    count_s   = count_r;
    fetch_pc_s = fetch_pc_r;
    resp_pc_s  = resp_pc_r;
    if (redirect_valid) begin
      // The response at this edge is charged to the pre-redirect counters
      // first; whatever is still live, plus a request accepted right now,
      // becomes drop.
      live_s     = 4'd0;
      drop_s     = drop_r - {3'b000, dropped_s} + live_r - {3'b000, pushed_s}
                   + {3'b000, accept_s};
      count_s    = 4'd0;
      fetch_pc_s = target_s;
      resp_pc_s  = target_s;
    end else begin
      live_s  = live_r + {3'b000, accept_s} - {3'b000, pushed_s};
      drop_s  = drop_r - {3'b000, dropped_s};
      count_s = count_r + {3'b000, write_s} - {3'b000, pop_s};
      if (accept_s) begin
        fetch_pc_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
      if (pushed_s) begin
        resp_pc_s = resp_pc_r + 32'd4;
      end else begin
        resp_pc_s = resp_pc_r;
      end
    end
    // Credits evaluated on post-edge counters. Without a redirect the sums
    // can only shrink while a request waits, so valid stays up until ready.
    req_valid_s = (state_s == RUN) && !redirect_valid
                  && ((count_s + live_s) < DEPTH_C)
                  && ((live_s + drop_s) < MAX_C);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BOOT;
      fetch_pc_r  <= RESET_PC;
      resp_pc_r   <= RESET_PC;
      req_valid_r <= 1'b0;
      live_r      <= 4'd0;
      drop_r      <= 4'd0;
      count_r     <= 4'd0;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      resp_pc_r   <= resp_pc_s;
      req_valid_r <= req_valid_s;
      live_r      <= live_s;
      drop_r      <= drop_s;
      count_r     <= count_s;
    end
  end

  // Instruction buffer storage and pointers; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_r[i] <= NOP;
        pc_mem_r[i]    <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (write_s) begin
        instr_mem_r[wr_ptr_r] <= imem_resp_data;
        pc_mem_r[wr_ptr_r]    <= resp_pc_r;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Output drive: FIFO head when non-empty, NOP/0 otherwise.
  always_comb begin
    imem_req_valid = req_valid_r;
    imem_req_addr  = fetch_pc_r;
    if (count_r != 4'd0) begin
      if_valid = 1'b1;
      if_instr = instr_mem_r[rd_ptr_r];
      if_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      if_valid = 1'b0;
      if_instr = NOP;
      if_pc    = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random imem latency/backpressure and
// redirects, with a reference model that simply expects decode to see a
// sequential PC stream restarting at every redirect target.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        imem_q[$];     // accepted requests awaiting a response
  logic [31:0] exp_q[$];      // PCs decode is expected to receive next
  logic [31:0] ref_next_pc;
  logic [31:0] mon_exp;
  logic [31:0] last_pc = 32'h0;
  bit          saw_wrap = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          max_lat = 0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  bit          first_req_check = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(ref_next_pc);
      ref_next_pc += 32'd4;
    end
  endtask

  // One clock of stimulus: imem model response, inputs, request capture.
  task automatic step(input bit rdy, input bit rq_rdy, input bit redir,
                      input logic [31:0] rpc);
    req_t r;
    @(negedge clk);
    cyc++;
    if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      r = imem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(r.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    if_ready       = rdy;
    imem_req_ready = rq_rdy;
    redirect_valid = redir;
    redirect_pc    = redir ? rpc : $urandom;
    if (redir) begin
      exp_q.delete();
      ref_next_pc = rpc & 32'hFFFF_FFFC;
      top_up();
    end
    #1;
    if (prev_pending) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    chk("req_align", 32'(imem_req_addr[1:0]), 32'd0);
    if (imem_req_valid && rq_rdy) begin
      if (first_req_check) begin
        chk("first_req_addr", imem_req_addr, RESET_PC);
        first_req_check = 1'b0;
      end
      r.addr = imem_req_addr;
      r.due  = cyc + 1 + $urandom_range(0, max_lat);
      imem_q.push_back(r);
    end
    chk("outstanding_limit", 32'(imem_q.size() <= MAX_OUT), 32'd1);
    prev_pending = imem_req_valid && !rq_rdy && !redir;
    prev_addr    = imem_req_addr;
  endtask

  // Monitor: compares every instruction decode actually consumes.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) top_up();
        mon_exp = exp_q.pop_front();
        top_up();
        chk("if_pc", if_pc, mon_exp);
        chk("if_instr", if_instr, mem_word(mon_exp));
        if (mon_exp == 32'h0 && last_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        last_pc = mon_exp;
        pop_cnt++;
      end else if (!if_valid) begin
        chk("idle_instr", if_instr, 32'h0000_0013);
        chk("idle_pc", if_pc, 32'h0);
      end
    end
  end

  logic [31:0] hold_pc, hold_instr;
  int          k;
  int          base_pops;
  logic [31:0] rpc;

  initial begin
    ref_next_pc = RESET_PC;
    top_up();
    first_req_check = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);

    // Steady flow with 1-cycle memory and decode always ready.
    max_lat = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("steady_progress", 32'(pop_cnt >= 8), 32'd1);

    // Directed redirects: in-flight drop, back-to-back, unaligned target.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0050);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic.
    max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 4095));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0, rpc);
    end

    // Decode stall: buffer fills to FIFO_DEPTH and requests stop.
    max_lat = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 4) begin
        hold_pc    = if_pc;
        hold_instr = if_instr;
      end
    end
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    chk("stall_pc_stable", if_pc, hold_pc);
    chk("stall_instr_stable", if_instr, hold_instr);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (if_valid) k++;
      else break;
    end
    chk("stall_buffered", 32'(k), 32'(FIFO_DEPTH));

    // PC wrap at the top of the address space.
    base_pops = pop_cnt;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_progress", 32'(pop_cnt - base_pops >= 6), 32'd1);

    // Reset in the middle of a stall with the buffer full.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("pre_reset_full", 32'(if_valid), 32'd1);
    rst_n           = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_if_instr", if_instr, 32'h0000_0013);
    chk("mid_rst_if_pc", if_pc, 32'h0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_req_addr", imem_req_addr, RESET_PC);
    imem_q.delete();
    exp_q.delete();
    ref_next_pc = RESET_PC;
    top_up();
    prev_pending    = 1'b0;
    first_req_check = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_pops = pop_cnt;
    max_lat = 3;
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, 1'b0, 32'h0);
    chk("post_reset_first_req", 32'(first_req_check), 32'd0);
    chk("post_reset_progress", 32'(pop_cnt - base_pops >= 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
